// File: rtl/memory_responder.sv
// memory_responder: MAR/MDR registers, word RAM and fixed-latency MEM.EN/R handshake
module memory_responder #(
  parameter int ADDR_BITS = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] marIn,
  input  logic        ldMAR,
  input  logic [15:0] busIn,
  input  logic        ldMDR,
  input  logic        selMDR,
  input  logic        memEN,
  input  logic        memWE,
  output logic [15:0] MAR,
  output logic [15:0] MDR,
  output logic [15:0] readData,
  output logic        memReady,
  output logic        memBusy
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, nextState;
  logic [3:0] cnt;
  logic [15:0] accAddr, accData;
  logic accWE;
  logic [15:0] mem [2**ADDR_BITS];
  logic inRange, access;
  logic [ADDR_BITS-1:0] idx;
  assign inRange = (accAddr >> ADDR_BITS) == 16'd0;
  assign access = state == WAIT && cnt == 4'd0;
  assign idx = accAddr[ADDR_BITS-1:0];
  // state register; reset aborts any access in flight
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nextState;
  // next state and state-decoded handshake outputs
  always_comb begin
    nextState = state == IDLE ? (memEN ? WAIT : IDLE) :
                state == WAIT ? (cnt == 4'd0 ? DONE : WAIT) : IDLE;
    memReady = state == DONE;
    memBusy = state != IDLE;
  end
  // operand latch at request time and wait countdown
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= 4'd0;
      accAddr <= 16'h0000;
      accData <= 16'h0000;
      accWE <= 1'b0;
    end else if (state == IDLE && memEN) begin
      cnt <= 4'(WAIT_CYCLES);
      accAddr <= MAR;
      accData <= MDR;
      accWE <= memWE;
    end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
  // MAR/MDR loads in any state and registered read result
  always_ff @(posedge clk)
    if (reset) begin
      MAR <= 16'h0000;
      MDR <= 16'h0000;
      readData <= 16'h0000;
    end else begin
      if (ldMAR) MAR <= marIn;
      if (ldMDR) MDR <= selMDR ? readData : busIn;
      if (access && !accWE) readData <= inRange ? mem[idx] : 16'h0000;
    end
  // RAM write; out-of-range writes and writes colliding with reset are dropped
  always_ff @(posedge clk)
    if (!reset && access && accWE && inRange) mem[idx] <= accData;
endmodule
